// File: rtl/wb_stage_p.sv
// wb_stage_p: MEM/WB pipeline register fused with writeback (load extraction, GRF write, MTC0 hold)
// Ports: clk/rst_n (async active-low), stall_i/flush_i stage control,
//   *_MemWb incoming MEM-stage results, pc_Id/grfWa_Id/grfWd_Id/ifWrGrf_Id GRF write port,
//   ifMtc0_If MTC0 hazard hold toward IF, wbBusy_o stage occupancy.
// Optional macro WB_RETIRE_CNT_EN adds retireClr_i / retireCnt_o (saturating retire counter).
module wb_stage_p #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int GRF_AW    = 5,
  parameter int MTC0_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_MemWb,
  input  logic [PC_W-1:0]   pc_MemWb,
  input  logic [GRF_AW-1:0] grfWa_MemWb,
  input  logic              wrEn_MemWb,
  input  logic [1:0]        wdSel_MemWb,
  input  logic [2:0]        ldType_MemWb,
  input  logic [DATA_W-1:0] aluRes_MemWb,
  input  logic [DATA_W-1:0] memRd_MemWb,
  input  logic              ifMtc0_MemWb,
`ifdef WB_RETIRE_CNT_EN
  input  logic              retireClr_i,
  output logic [31:0]       retireCnt_o,
`endif
  output logic [PC_W-1:0]   pc_Id,
  output logic [GRF_AW-1:0] grfWa_Id,
  output logic [DATA_W-1:0] grfWd_Id,
  output logic              ifWrGrf_Id,
  output logic              ifMtc0_If,
  output logic              wbBusy_o
);
  localparam int CW = ($clog2(MTC0_HOLD + 1) < 1) ? 1 : $clog2(MTC0_HOLD + 1);
  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [GRF_AW-1:0] wa;
    logic              we;
    logic [1:0]        sel;
    logic [2:0]        ld;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd;
    logic              mtc0;
  } stage_t;
  stage_t stage_q, stage_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic retire, wr;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [DATA_W-1:0] ld_v, wd;
  always_comb begin
    stage_d = stage_q;
    if (flush_i) stage_d.valid = 1'b0;
    else if (!stall_i) stage_d = '{valid_MemWb, pc_MemWb, grfWa_MemWb, wrEn_MemWb, wdSel_MemWb,
                                   ldType_MemWb, aluRes_MemWb, memRd_MemWb, ifMtc0_MemWb};
  end
  assign retire = stage_q.valid & ~stall_i & ~flush_i;
  // a retiring MTC0 reloads (never accumulates); a running hold ignores flush
  assign cnt_d = (retire & stage_q.mtc0) ? CW'(MTC0_HOLD) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  // halfword lane uses alu[1] only; misaligned halfwords are not trapped here
  assign ld_b = stage_q.rd[{stage_q.alu[1:0], 3'b000} +: 8];
  assign ld_h = stage_q.rd[{stage_q.alu[1], 4'b0000} +: 16];
  assign ld_v = (stage_q.ld == 3'd1) ? {{(DATA_W-8){ld_b[7]}}, ld_b} :
                (stage_q.ld == 3'd2) ? {{(DATA_W-8){1'b0}}, ld_b} :
                (stage_q.ld == 3'd3) ? {{(DATA_W-16){ld_h[15]}}, ld_h} :
                (stage_q.ld == 3'd4) ? {{(DATA_W-16){1'b0}}, ld_h} : stage_q.rd;
  assign wd = (stage_q.sel == 2'd1) ? ld_v :
              (stage_q.sel == 2'd2) ? DATA_W'(stage_q.pc) + DATA_W'(8) : stage_q.alu;
  assign wr         = stage_q.valid & stage_q.we & (stage_q.wa != '0);
  assign ifWrGrf_Id = wr;
  assign grfWa_Id   = wr ? stage_q.wa : '0;
  assign grfWd_Id   = wr ? wd : '0;
  assign pc_Id      = stage_q.valid ? stage_q.pc : '0;
  assign wbBusy_o   = stage_q.valid;
  assign ifMtc0_If  = (stage_q.valid & stage_q.mtc0) | (cnt_q != '0);
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] rcnt_q, rcnt_d;
  assign rcnt_d = retireClr_i ? '0 :
                  (retire & (stage_q.we | stage_q.mtc0) & (rcnt_q != '1)) ? rcnt_q + 32'd1 : rcnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rcnt_q <= '0;
    else rcnt_q <= rcnt_d;
  assign retireCnt_o = rcnt_q;
`endif
endmodule
